// File: rtl/fifo_rd_cntrl.sv
// Read-side controller of an asynchronous FIFO: write-pointer synchronizer,
// binary/Gray read pointers, registered empty flag and registered read data.
module fifo_rd_cntrl #(
  parameter int FIFO_width   = 16,
  parameter int Pointer_Size = 4
) (
  input  logic                      rclk,
  input  logic                      rrst_n,
  input  logic                      r_inc,
  input  logic [Pointer_Size-1:0]   wptr_gray,
  input  logic [FIFO_width-1:0]     mem_r_data,
  output logic [Pointer_Size-2:0]   r_addr,
  output logic [Pointer_Size-1:0]   rptr_gray,
  output logic                      r_empty,
  output logic [FIFO_width-1:0]     r_data,
  output logic                      r_valid
);

  function automatic logic [Pointer_Size-1:0] bin2gray(input logic [Pointer_Size-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  logic [Pointer_Size-1:0] wq1, wq2;
  logic [Pointer_Size-1:0] rbin, rbin_next, rgray_next;
  logic                    accept;

  // Two-flop synchronizer for the Gray write pointer crossing into rclk
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      wq1 <= '0;
      wq2 <= '0;
    end else begin
      wq1 <= wptr_gray;
      wq2 <= wq1;
    end
  end

  always_comb begin
    accept     = r_inc & ~r_empty;
    rbin_next  = rbin + {{(Pointer_Size-1){1'b0}}, accept};
    rgray_next = bin2gray(rbin_next);
  end

  // Empty is computed from the next read pointer so the last read sets it on the same edge
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin      <= '0;
      rptr_gray <= '0;
      r_empty   <= 1'b1;
      r_data    <= '0;
      r_valid   <= 1'b0;
    end else begin
      rbin      <= rbin_next;
      rptr_gray <= rgray_next;
      r_empty   <= (rgray_next == wq2);
      r_valid   <= accept;
      if (accept)
        r_data <= mem_r_data;
    end
  end

  assign r_addr = rbin[Pointer_Size-2:0];

endmodule

// File: tb/tb_fifo_rd_cntrl.sv
// Directed testbench for fifo_rd_cntrl with a small behavioural memory and write-pointer model.
module tb_fifo_rd_cntrl;

  logic        rclk;
  logic        rrst_n;
  logic        r_inc;
  logic [3:0]  wptr_gray;
  logic [15:0] mem_r_data;
  logic [2:0]  r_addr;
  logic [3:0]  rptr_gray;
  logic        r_empty;
  logic [15:0] r_data;
  logic        r_valid;

  logic [15:0] mem [0:7];
  int checks = 0;
  int errors = 0;

  fifo_rd_cntrl #(.FIFO_width(16), .Pointer_Size(4)) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .r_inc      (r_inc),
    .wptr_gray  (wptr_gray),
    .mem_r_data (mem_r_data),
    .r_addr     (r_addr),
    .rptr_gray  (rptr_gray),
    .r_empty    (r_empty),
    .r_data     (r_data),
    .r_valid    (r_valid)
  );

  assign mem_r_data = mem[r_addr];

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  function automatic logic [3:0] gray4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge rclk);
    #3;
    rrst_n    = 1'b0;
    r_inc     = 1'b0;
    wptr_gray = 4'd0;
    @(posedge rclk);
    @(posedge rclk);
    #3;
    rrst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rrst_n = 1'b1; r_inc = 1'b0; wptr_gray = 4'd0;
    #13;
    rrst_n = 1'b0;
    #1;
    checks++; if (r_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b required 1", r_empty); end
    checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", r_valid); end
    checks++; if (r_addr !== 3'd0) begin errors++; $display("FAIL reset_addr: got %h required 0", r_addr); end
    checks++; if (rptr_gray !== 4'd0) begin errors++; $display("FAIL reset_rptr: got %b required 0000", rptr_gray); end
    checks++; if (r_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h required 0000", r_data); end
    #20;
    rrst_n = 1'b1;
    tick();
  endtask

  task automatic test_read_while_empty();
    do_reset();
    wptr_gray = 4'd0;
    r_inc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (r_valid !== 1'b0 || r_addr !== 3'd0 || rptr_gray !== 4'd0 || r_empty !== 1'b1) begin
        errors++;
        $display("FAIL empty_read cycle %0d: got valid=%b addr=%h rptr=%b empty=%b required 0 0 0000 1",
                 i, r_valid, r_addr, rptr_gray, r_empty);
      end
    end
    r_inc = 1'b0;
  endtask

  task automatic test_single_word();
    do_reset();
    mem[0] = 16'hA5A5;
    wptr_gray = 4'b0001;
    r_inc = 1'b1;
    tick();  // edge k
    tick();  // edge k+1
    checks++; if (r_empty !== 1'b1) begin errors++; $display("FAIL single_empty_k1: got %b required 1", r_empty); end
    tick();  // edge k+2
    checks++; if (r_empty !== 1'b0 || r_valid !== 1'b0) begin
      errors++; $display("FAIL single_empty_k2: got empty=%b valid=%b required 0 0", r_empty, r_valid);
    end
    tick();  // edge k+3
    checks++; if (r_data !== 16'hA5A5) begin errors++; $display("FAIL single_data: got %h required a5a5", r_data); end
    checks++; if (r_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b required 1", r_valid); end
    checks++; if (r_addr !== 3'd1 || rptr_gray !== 4'b0001) begin
      errors++; $display("FAIL single_ptr: got addr=%h rptr=%b required 1 0001", r_addr, rptr_gray);
    end
    checks++; if (r_empty !== 1'b1) begin errors++; $display("FAIL single_empty_after: got %b required 1", r_empty); end
    tick();
    checks++; if (r_valid !== 1'b0 || r_addr !== 3'd1 || r_data !== 16'hA5A5) begin
      errors++; $display("FAIL single_hold: got valid=%b addr=%h data=%h required 0 1 a5a5", r_valid, r_addr, r_data);
    end
    r_inc = 1'b0;
  endtask

  task automatic test_full_drain();
    do_reset();
    for (int i = 0; i < 8; i++) mem[i] = 16'(i);
    wptr_gray = 4'b1100;
    r_inc = 1'b1;
    tick(); tick(); tick();
    checks++; if (r_empty !== 1'b0 || r_valid !== 1'b0) begin
      errors++; $display("FAIL drain_start: got empty=%b valid=%b required 0 0", r_empty, r_valid);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (r_valid !== 1'b1 || r_data !== 16'(i)) begin
        errors++; $display("FAIL drain_word %0d: got valid=%b data=%h required 1 %h", i, r_valid, r_data, 16'(i));
      end
    end
    checks++; if (rptr_gray !== 4'b1100 || r_addr !== 3'd0 || r_empty !== 1'b1) begin
      errors++; $display("FAIL drain_final: got rptr=%b addr=%h empty=%b required 1100 0 1", rptr_gray, r_addr, r_empty);
    end
    tick();
    checks++; if (r_valid !== 1'b0 || rptr_gray !== 4'b1100) begin
      errors++; $display("FAIL drain_stop: got valid=%b rptr=%b required 0 1100", r_valid, rptr_gray);
    end
    r_inc = 1'b0;
  endtask

  task automatic test_wrap_around();
    int rd, wb;
    logic acc;
    logic [3:0] prev;
    do_reset();
    rd = 0; wb = 0; prev = rptr_gray;
    for (int cyc = 0; cyc < 600 && rd < 20; cyc++) begin
      if (wb < 20 && (wb - rd) < 8) begin
        mem[wb % 8] = 16'h1000 + 16'(wb);
        wb++;
        wptr_gray = gray4(4'(wb));
      end
      r_inc = ($urandom_range(0, 3) != 0);
      acc = r_inc && !r_empty;
      tick();
      checks++; if (r_valid !== acc) begin
        errors++; $display("FAIL wrap_valid cycle %0d: got %b required %b", cyc, r_valid, acc);
      end
      if (r_valid === 1'b1) begin
        checks++; if (r_data !== 16'h1000 + 16'(rd)) begin
          errors++; $display("FAIL wrap_data %0d: got %h required %h", rd, r_data, 16'h1000 + 16'(rd));
        end
        rd++;
      end
      checks++; if (rptr_gray !== gray4(4'(rd)) || $countones(rptr_gray ^ prev) > 1) begin
        errors++; $display("FAIL wrap_rptr cycle %0d: got %b (prev %b) required %b", cyc, rptr_gray, prev, gray4(4'(rd)));
      end
      prev = rptr_gray;
    end
    checks++; if (rd != 20) begin errors++; $display("FAIL wrap_count: got %0d words required 20", rd); end
    r_inc = 1'b0;
    tick();
    checks++; if (r_addr !== 3'd4 || rptr_gray !== 4'b0110 || r_empty !== 1'b1) begin
      errors++; $display("FAIL wrap_final: got addr=%h rptr=%b empty=%b required 4 0110 1", r_addr, rptr_gray, r_empty);
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    for (int i = 0; i < 8; i++) mem[i] = 16'h2000 + 16'(i);
    wptr_gray = 4'b1100;
    r_inc = 1'b1;
    tick(); tick(); tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (r_valid !== 1'b1 || r_data !== 16'h2000 + 16'(i)) begin
        errors++; $display("FAIL midrst_pre %0d: got valid=%b data=%h required 1 %h", i, r_valid, r_data, 16'h2000 + 16'(i));
      end
    end
    #2;
    rrst_n = 1'b0;
    #1;
    checks++; if (r_empty !== 1'b1 || r_valid !== 1'b0 || r_addr !== 3'd0 || rptr_gray !== 4'd0 || r_data !== 16'h0) begin
      errors++; $display("FAIL midrst_clear: got empty=%b valid=%b addr=%h rptr=%b data=%h required 1 0 0 0000 0000",
                         r_empty, r_valid, r_addr, rptr_gray, r_data);
    end
    @(posedge rclk);
    #3;
    rrst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (r_valid !== 1'b0 || r_addr !== 3'd0) begin
        errors++; $display("FAIL midrst_sync %0d: got valid=%b addr=%h required 0 0", i, r_valid, r_addr);
      end
    end
    tick();
    checks++; if (r_valid !== 1'b1 || r_data !== 16'h2000 || r_addr !== 3'd1) begin
      errors++; $display("FAIL midrst_restart: got valid=%b data=%h addr=%h required 1 2000 1", r_valid, r_data, r_addr);
    end
    r_inc = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 16'h0;
    test_reset();
    test_read_while_empty();
    test_single_word();
    test_full_drain();
    test_wrap_around();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_cntrl.md
# fifo_rd_cntrl

Read-side controller of the asynchronous FIFO, in the read clock domain. It synchronizes the Gray-coded write pointer and maintains the binary and Gray read pointers. It generates the empty flag, drives the read address into the FIFO memory, and registers the read data with a one-cycle valid strobe. It pairs with the write-side memory/controller and exports its Gray read pointer for full detection in the write domain.

## Interface
Parameters:
- FIFO_width, 16, data word width
- Pointer_Size, 4, pointer width in bits; address width is Pointer_Size-1; depth is 2^(Pointer_Size-1) = 8

Ports:
- rclk  in  1  read clock; one clock; reset is asynchronous and active-low
- rrst_n  in  1  asynchronous active-low reset
- r_inc  in  1  read request; accepted only when r_empty is 0
- wptr_gray  in  Pointer_Size  Gray write pointer from write domain, unsynchronized
- mem_r_data  in  FIFO_width  combinational memory output at r_addr
- r_addr  out  Pointer_Size-1  memory read address
- rptr_gray  out  Pointer_Size  registered Gray read pointer, to write domain
- r_empty  out  1  FIFO empty, registered
- r_data  out  FIFO_width  registered read word
- r_valid  out  1  one-cycle strobe, r_data updated this cycle

## Operation
- Synchronizer: two flops in series, wq1 <= wptr_gray and wq2 <= wq1. No logic between the two stages.
- Binary read pointer rbin is Pointer_Size bits wide.
  - accept = r_inc & ~r_empty
  - rbin_next = rbin + accept, modulo 2^Pointer_Size
- Gray conversion: rgray_next = (rbin_next >> 1) ^ rbin_next. rptr_gray is registered from rgray_next, so it always changes by exactly one bit per accept.
- r_addr = rbin[Pointer_Size-2:0], driven directly from the register.
- Empty: r_empty <= (rgray_next == wq2). The full Pointer_Size bits are compared, including the MSB wrap bit.
- On accept:
  - r_data <= mem_r_data, which is the word at the pre-increment r_addr
  - r_valid <= 1
- Otherwise: r_valid <= 0 and r_data holds its value.
- r_inc while r_empty = 1 is ignored: pointers, r_addr and r_data are unchanged, and r_valid = 0. No underflow is possible.
- Wrap-around: after 8 accepts r_addr returns to 0 and the rbin MSB toggles. Empty compares remain correct across any number of wraps.
- The block never writes to memory and has no knowledge of full.
- Reset values, all asynchronous on rrst_n low:
  - rbin, rptr_gray, r_addr = 0
  - wq1, wq2 = 0
  - r_empty = 1
  - r_data = 0
  - r_valid = 0
- Reset asserted mid-operation clears all state immediately, with no clock required. The first edge after release behaves as a fresh FIFO. A pending r_inc on the release edge is ignored, because r_empty = 1.

## Timing
- All state updates on the rising edge of rclk.
- Read latency: r_inc accepted at edge n gives r_data and r_valid valid after edge n. r_valid drops after edge n+1 unless another accept occurs.
- Back-to-back reads: r_inc held high with data available gives one word per cycle.
- Write-to-not-empty latency:
  - wptr_gray changes before edge k
  - wq1 updates at k, wq2 at k+1
  - r_empty falls at edge k+2
- The last read to empty is pessimistic-free. The accept that makes rgray_next equal to wq2 sets r_empty at the same edge, so no extra r_inc is accepted.
- Simultaneous accept and wq2 change: r_empty is evaluated against the already-registered wq2 and the new rgray_next. A newer write is seen no later than two edges later.
- r_empty may remain high for up to 3 edges after a write; this is conservative and allowed. It must never be low when the FIFO is actually empty.

## Test plan
- Reset: hold rrst_n low mid-clock. Required response:
  - r_empty = 1
  - r_valid = 0
  - r_addr = 0
  - rptr_gray = 0
  - r_data = 0
- Single word:
  - Stimulus: memory holds 0xA5A5 at address 0; wptr_gray set to 0001 before edge k; r_inc high from then on.
  - r_empty falls at edge k+2.
  - The accept at edge k+3 gives r_data = 0xA5A5, r_valid = 1, r_addr = 1, rptr_gray = 0001, r_empty = 1.
- Read while empty: hold r_inc high for 5 cycles after reset with wptr_gray = 0. Required: no r_valid pulse, r_addr stays 0, rptr_gray stays 0.
- Full drain:
  - Stimulus: wptr_gray = 1100 (binary 8); memory holds 0x0000..0x0007; r_inc continuous.
  - Required: eight consecutive r_valid pulses with r_data = 0..7.
  - Final state: rptr_gray = 1100, r_addr = 0, r_empty = 1.
- Wrap-around:
  - Stimulus: stream 20 words, with the write-pointer model advancing in Gray code and random r_inc gaps.
  - Required: data order preserved, one r_valid per accept, rptr_gray changes by one bit per step, final rbin = 20 mod 16 = 4.
- Reset mid-read: assert rrst_n during a burst after 3 reads. Required: all outputs return to reset values immediately; reads restart from address 0 after release.
